// File: rtl/agc_ctrl.sv
// AGC sequencer: arms the AGC on rx_en, detects packet energy, applies and settles the gain decision, then freezes gain through the packet.
// Optional AGC_CTRL_KEEP_GAIN_EN: keep the current gain on a LOCK sync-window miss instead of restoring DEFAULT_GAIN.
module agc_ctrl #(
   parameter int CONTROL_WORD_WIDTH = 8,
   parameter int RSSI_WIDTH = 16,
   parameter logic [CONTROL_WORD_WIDTH-1:0] DEFAULT_GAIN = 8'h80,
   parameter int DETECT_THRESH = -60*256,
   parameter int DETECT_COUNT = 4,
   parameter int ACQ_TIMEOUT = 64,
   parameter int SETTLE_CYCLES = 8,
   parameter int SYNC_WINDOW = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx_en,
   input  logic                          data_valid,
   input  logic signed [RSSI_WIDTH-1:0]  rssi_dbfs,
   input  logic                          rssi_valid,
   input  logic [CONTROL_WORD_WIDTH-1:0] control_word,
   input  logic                          control_word_valid,
   input  logic                          sync_found,
   input  logic                          pkt_done,
   output logic                          agc_clr,
   output logic                          agc_data_valid,
   output logic [CONTROL_WORD_WIDTH-1:0] gain_word,
   output logic                          gain_load,
   output logic                          gain_frozen,
   output logic                          acq_timeout,
   output logic [2:0]                    state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      ACQUIRE = 3'd2,
      SETTLE  = 3'd3,
      LOCK    = 3'd4,
      HOLD    = 3'd5
   } state_t;

   localparam logic signed [RSSI_WIDTH-1:0] THRESH = RSSI_WIDTH'(DETECT_THRESH);
   localparam logic [2:0] DETECT_LAST = 3'(DETECT_COUNT - 1);
   localparam logic [8:0] ACQ_LAST    = 9'(ACQ_TIMEOUT - 1);
   localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_CYCLES - 1);
   localparam logic [8:0] SYNC_LAST   = 9'(SYNC_WINDOW - 1);

   state_t                          state_reg, state_next;
   logic [8:0]                      sample_cnt_reg, sample_cnt_next;
   logic [2:0]                      det_cnt_reg, det_cnt_next;
   logic [CONTROL_WORD_WIDTH-1:0]   gain_reg, gain_next;
   logic                            load_reg, load_next;
   logic                            clr_reg, clr_next;
   logic                            tmo_reg, tmo_next;
   logic                            frozen_reg, frozen_next;
   logic                            rssi_above;

   assign rssi_above = rssi_dbfs > THRESH;

   function automatic logic [8:0] sat_inc(input logic [8:0] v);
      return (v == 9'h1FF) ? v : v + 9'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         sample_cnt_reg <= '0;
         det_cnt_reg    <= '0;
         gain_reg       <= DEFAULT_GAIN;
         load_reg       <= 1'b0;
         clr_reg        <= 1'b0;
         tmo_reg        <= 1'b0;
         frozen_reg     <= 1'b0;
      end else begin
         state_reg      <= state_next;
         sample_cnt_reg <= sample_cnt_next;
         det_cnt_reg    <= det_cnt_next;
         gain_reg       <= gain_next;
         load_reg       <= load_next;
         clr_reg        <= clr_next;
         tmo_reg        <= tmo_next;
         frozen_reg     <= frozen_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      sample_cnt_next = sample_cnt_reg;
      det_cnt_next    = '0;
      if (!rx_en) begin
         state_next      = IDLE;
         sample_cnt_next = '0;
      end else if (state_reg == HOLD && pkt_done) begin
         state_next = ARM;
      end else begin
         case (state_reg)
            IDLE: state_next = ARM;
            ARM: begin
               det_cnt_next = det_cnt_reg;
               if (rssi_valid) begin
                  if (!rssi_above) begin
                     det_cnt_next = '0;
                  end else if (det_cnt_reg == DETECT_LAST) begin
                     state_next      = ACQUIRE;
                     sample_cnt_next = '0;
                     det_cnt_next    = '0;
                  end else begin
                     det_cnt_next = det_cnt_reg + 3'd1;
                  end
               end
            end
            ACQUIRE: begin
               // A decision on the timeout sample takes precedence over the timeout
               if (control_word_valid) begin
                  state_next      = SETTLE;
                  sample_cnt_next = '0;
               end else if (data_valid) begin
                  if (sample_cnt_reg == ACQ_LAST) begin
                     state_next      = ARM;
                     sample_cnt_next = '0;
                  end else begin
                     sample_cnt_next = sat_inc(sample_cnt_reg);
                  end
               end
            end
            SETTLE: begin
               if (sample_cnt_reg == SETTLE_LAST) begin
                  state_next      = LOCK;
                  sample_cnt_next = '0;
               end else begin
                  sample_cnt_next = sat_inc(sample_cnt_reg);
               end
            end
            LOCK: begin
               if (sync_found) begin
                  state_next = HOLD;
               end else if (data_valid) begin
                  if (sample_cnt_reg == SYNC_LAST) begin
                     state_next      = ARM;
                     sample_cnt_next = '0;
                  end else begin
                     sample_cnt_next = sat_inc(sample_cnt_reg);
                  end
               end
            end
            HOLD:    state_next = HOLD;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      gain_next   = gain_reg;
      load_next   = 1'b0;
      clr_next    = 1'b0;
      tmo_next    = 1'b0;
      frozen_next = (state_next == LOCK) || (state_next == HOLD);
      if (!rx_en) begin
         gain_next = DEFAULT_GAIN;
         load_next = (gain_reg != DEFAULT_GAIN);
      end else if (state_next == ARM && state_reg != ARM) begin
         clr_next = 1'b1;
         tmo_next = (state_reg == ACQUIRE);
         if (state_reg == IDLE) begin
            gain_next = DEFAULT_GAIN;
            load_next = (gain_reg != DEFAULT_GAIN);
         end else if (state_reg == LOCK) begin
`ifdef AGC_CTRL_KEEP_GAIN_EN
            gain_next = gain_reg;
            load_next = 1'b0;
`else
            gain_next = DEFAULT_GAIN;
            load_next = 1'b1;
`endif
         end else begin
            gain_next = DEFAULT_GAIN;
            load_next = 1'b1;
         end
      end else if (state_reg == ACQUIRE && state_next == SETTLE) begin
         gain_next = control_word;
         load_next = 1'b1;
      end
   end

   assign agc_data_valid = data_valid && (state_reg == ARM || state_reg == ACQUIRE);
   assign agc_clr        = clr_reg;
   assign gain_word      = gain_reg;
   assign gain_load      = load_reg;
   assign gain_frozen    = frozen_reg;
   assign acq_timeout    = tmo_reg;
   assign state          = state_reg;

endmodule

// File: tb/tb_agc_ctrl.sv
// Directed bench for agc_ctrl: expected output snapshots and pulse counts are queued
// when stimulus is driven and popped when the DUT output is sampled.
module tb_agc_ctrl;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rx_en = 1'b0;
   logic              data_valid = 1'b0;
   logic signed [15:0] rssi_dbfs = '0;
   logic              rssi_valid = 1'b0;
   logic [7:0]        control_word = '0;
   logic              control_word_valid = 1'b0;
   logic              sync_found = 1'b0;
   logic              pkt_done = 1'b0;
   logic              agc_clr, agc_data_valid, gain_load, gain_frozen, acq_timeout;
   logic [7:0]        gain_word;
   logic [2:0]        state;

   localparam logic signed [15:0] ABOVE = 16'(-40*256);
   localparam logic signed [15:0] BELOW = 16'(-70*256);
   localparam logic signed [15:0] AT_TH = 16'(-60*256);
`ifdef AGC_CTRL_KEEP_GAIN_EN
   localparam logic [7:0] MISS_GAIN  = 8'h30;
   localparam logic       MISS_LOAD  = 1'b0;
   localparam int         MISS_LOADS = 0;
`else
   localparam logic [7:0] MISS_GAIN  = 8'h80;
   localparam logic       MISS_LOAD  = 1'b1;
   localparam int         MISS_LOADS = 1;
`endif

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   n_load = 0, n_clr = 0, n_tmo = 0;
   int   l0, c0, t0;

   agc_ctrl dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .rx_en              (rx_en),
      .data_valid         (data_valid),
      .rssi_dbfs          (rssi_dbfs),
      .rssi_valid         (rssi_valid),
      .control_word       (control_word),
      .control_word_valid (control_word_valid),
      .sync_found         (sync_found),
      .pkt_done           (pkt_done),
      .agc_clr            (agc_clr),
      .agc_data_valid     (agc_data_valid),
      .gain_word          (gain_word),
      .gain_load          (gain_load),
      .gain_frozen        (gain_frozen),
      .acq_timeout        (acq_timeout),
      .state              (state)
   );

   always #5 clk = ~clk;

   // Strobes are sampled mid-cycle so each one-cycle pulse is counted exactly once
   always @(negedge clk) begin
      if (gain_load)   n_load++;
      if (agc_clr)     n_clr++;
      if (acq_timeout) n_tmo++;
   end

   function automatic logic [31:0] outs();
      return {16'h0, state, gain_word, gain_load, agc_clr, acq_timeout, gain_frozen, agc_data_valid};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_out(input string tag, input logic [2:0] st, input logic [7:0] gw,
                           input logic ld, input logic clr, input logic tmo,
                           input logic frz, input logic adv);
      exp_t e;
      e.tag = tag;
      e.val = {16'h0, st, gw, ld, clr, tmo, frz, adv};
      sb.push_back(e);
   endtask

   task automatic push_cnt(input string tag, input int cnt);
      exp_t e;
      e.tag = tag;
      e.val = 32'(cnt);
      sb.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      tests_run++;
      if (sb.size() == 0) begin
         tests_failed++;
         $error("FAIL sb_empty: observed %0h required <queued entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
         end
         $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, e.tag, obs, e.val);
      end
   endtask

   task automatic check_out();
      pop_chk(outs());
   endtask

   task automatic check_cnt(input int obs);
      pop_chk(32'(obs));
   endtask

   initial begin
      // Reset state
      tick(2);
      push_out("reset", 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out();

      // Full packet
      rst_n = 1'b1;
      rx_en = 1'b1;
      push_out("idle_to_arm", 3'd1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      data_valid = 1'b1; rssi_valid = 1'b1; rssi_dbfs = ABOVE;
      tick(3);
      push_out("arm_3_above", 3'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out();
      push_out("arm_to_acq", 3'd2, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();
      tick(5);
      l0 = n_load;
      control_word = 8'h5A; control_word_valid = 1'b1;
      push_out("decision", 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      control_word_valid = 1'b0;
      tick(7);
      push_out("settle_7", 3'd3, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out();
      push_out("lock_entry", 3'd4, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1); check_out();
      tick(20);
      sync_found = 1'b1;
      push_out("sync", 3'd5, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1); check_out();
      sync_found = 1'b0;
      push_cnt("loads_in_pkt", 1);
      check_cnt(n_load - l0);
      pkt_done = 1'b1;
      push_out("pkt_done", 3'd1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();
      pkt_done = 1'b0;

      // Detect counter reset by a sample below and a sample equal to the threshold
      tick(3);
      rssi_dbfs = BELOW; tick(1);
      rssi_dbfs = ABOVE; tick(3);
      push_out("det_reset_below", 3'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out();
      rssi_dbfs = AT_TH; tick(1);
      rssi_dbfs = ABOVE; tick(3);
      push_out("det_reset_equal", 3'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out();
      push_out("det_4th", 3'd2, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();

      // Acquire timeout
      c0 = n_clr; t0 = n_tmo;
      tick(63);
      push_out("acq_63", 3'd2, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_out();
      push_out("acq_timeout", 3'd1, 8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick(1); check_out();
      tick(1);
      push_cnt("tmo_pulses", 1);
      check_cnt(n_tmo - t0);
      push_cnt("clr_pulses", 1);
      check_cnt(n_clr - c0);
      tick(2);
      push_out("acq2_entry", 3'd2, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();

      // Decision on the timeout sample wins
      tick(63);
      control_word = 8'h30; control_word_valid = 1'b1;
      push_out("cw_on_timeout", 3'd3, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      control_word_valid = 1'b0;
      tick(8);
      push_out("lock2", 3'd4, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_out();

      // Sync window miss
      l0 = n_load;
      tick(255);
      push_out("lock_255", 3'd4, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_out();
      push_out("sync_miss", 3'd1, MISS_GAIN, MISS_LOAD, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();
      tick(1);
      push_cnt("miss_loads", MISS_LOADS);
      check_cnt(n_load - l0);
      tick(2);
      push_out("acq3_entry", 3'd2, MISS_GAIN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();

      // Sync on the window expiry sample wins
      control_word = 8'h5A; control_word_valid = 1'b1;
      push_out("decision3", 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      control_word_valid = 1'b0;
      tick(8 + 255);
      sync_found = 1'b1;
      push_out("sync_on_expiry", 3'd5, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick(1); check_out();
      sync_found = 1'b0;

      // Asynchronous reset in HOLD
      #2;
      rst_n = 1'b0;
      #1;
      push_out("async_reset", 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_out();
      #2;
      rst_n = 1'b1;
      push_out("rearm", 3'd1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();

      // rx_en abort in SETTLE
      tick(3);
      push_out("acq4_entry", 3'd2, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(1); check_out();
      control_word_valid = 1'b1;
      push_out("decision4", 3'd3, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      control_word_valid = 1'b0;
      tick(3);
      rx_en = 1'b0;
      push_out("abort", 3'd0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();
      push_out("idle_no_load", 3'd0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(1); check_out();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/agc_ctrl.md
# agc_ctrl

Sequencer around the `agc` RSSI/gain datapath in the BLE receive front end. It arms the AGC when the receiver is enabled and detects packet energy from the RSSI stream. It accepts the AGC's single control-word decision, applies it to the analog gain stage, waits for gain settling, then freezes gain through the packet. Gain returns to a default value on sync miss, timeout, packet end or receiver disable.

## Interface
- `CONTROL_WORD_WIDTH`, 8, width of the gain word.
- `RSSI_WIDTH`, 16, width of signed Q8.8 `rssi_dbfs`.
- `DEFAULT_GAIN`, 8'h80, gain word applied in IDLE/ARM.
- `DETECT_THRESH`, -60*256, signed Q8.8 energy-detect level.
- `DETECT_COUNT`, 4, consecutive `rssi_valid` samples above threshold needed to trigger.
- `ACQ_TIMEOUT`, 64, `data_valid` samples allowed in ACQUIRE.
- `SETTLE_CYCLES`, 8, clocks to wait after a gain load.
- `SYNC_WINDOW`, 256, `data_valid` samples allowed in LOCK for access-address sync.

Ports:
- `clk` in 1: 8 MHz sample clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_en` in 1: receiver enable, level.
- `data_valid` in 1: I/Q sample strobe, same as fed to `agc`.
- `rssi_dbfs` in RSSI_WIDTH: signed Q8.8 from `agc`.
- `rssi_valid` in 1: qualifies `rssi_dbfs`.
- `control_word` in CONTROL_WORD_WIDTH: AGC decision.
- `control_word_valid` in 1: qualifies `control_word`.
- `sync_found` in 1: one-cycle pulse from the demodulator on access-address match.
- `pkt_done` in 1: one-cycle pulse at end of packet.
- `agc_clr` out 1: one-cycle synchronous clear to `agc`.
- `agc_data_valid` out 1: `data_valid` gated to `agc`, active only in ARM/ACQUIRE.
- `gain_word` out CONTROL_WORD_WIDTH: word driven to the analog gain stage.
- `gain_load` out 1: one-cycle strobe coincident with every `gain_word` change.
- `gain_frozen` out 1: high in LOCK and HOLD.
- `acq_timeout` out 1: one-cycle pulse on ACQUIRE timeout.
- `state` out 3: IDLE=0, ARM=1, ACQUIRE=2, SETTLE=3, LOCK=4, HOLD=5.

## Operation
- IDLE: if `rx_en`, go to ARM and pulse `agc_clr`.
- ARM: the detect counter increments on `rssi_valid` with `rssi_dbfs > DETECT_THRESH` (signed compare), and clears on `rssi_valid` below or equal to the threshold. When it reaches DETECT_COUNT, go to ACQUIRE and clear the sample counter.
- ACQUIRE:
  - On `control_word_valid`, latch `control_word` into `gain_word`, pulse `gain_load`, and go to SETTLE.
  - Otherwise, after ACQ_TIMEOUT `data_valid` samples, pulse `acq_timeout`, restore DEFAULT_GAIN with `gain_load`, pulse `agc_clr`, and go to ARM.
- SETTLE: count SETTLE_CYCLES clocks, then go to LOCK with the sample counter cleared. `gain_word` does not change in SETTLE.
- LOCK:
  - `sync_found` goes to HOLD.
  - If SYNC_WINDOW samples pass without sync, restore DEFAULT_GAIN with `gain_load`, pulse `agc_clr`, and go to ARM.
- HOLD: `pkt_done` restores DEFAULT_GAIN with `gain_load`, pulses `agc_clr`, and goes to ARM.
- Priority, highest first:
  - `rx_en` low in any state goes to IDLE next cycle and restores DEFAULT_GAIN; `gain_load` pulses only if the gain value differs.
  - `pkt_done`, which is ignored outside HOLD.
  - State-local events.
- Simultaneous events:
  - `sync_found` coincident with window expiry: sync wins.
  - `control_word_valid` coincident with timeout: the decision wins.
- Counters saturate and never wrap. The sample counter is 9 bits and the detect counter is 3 bits.

## Timing
- Reset values: `state`=IDLE, `gain_word`=DEFAULT_GAIN, all strobes 0, `gain_frozen`=0, all counters 0.
- All outputs are registered except `agc_data_valid`, which is combinational: `data_valid & (state==ARM | state==ACQUIRE)`.
- `control_word_valid` at edge N produces `gain_word`/`gain_load` at edge N+1 and state=SETTLE at N+1.
- LOCK is entered at N+1+SETTLE_CYCLES.
- Threshold crossing: the DETECT_COUNT-th qualifying `rssi_valid` at edge N gives state=ACQUIRE at N+1.
- `agc_clr` asserts in the same cycle the state register becomes ARM.
- Reset asserted mid-operation returns asynchronously to reset values. No `gain_load` is issued during reset.

## Configuration
- `AGC_CTRL_KEEP_GAIN_EN`:
  - Defined: on LOCK sync-window expiry, the controller keeps the current `gain_word` (no `gain_load`) when returning to ARM. This suits retrying a packet at the same level.
  - Undefined: it restores DEFAULT_GAIN as specified above.
  - Other exits to ARM are unaffected in both cases.

## Test plan
- Full packet: `rx_en`=1, then 4 samples at `rssi_dbfs`=-40*256, then `control_word_valid` with 8'h5A, then `sync_found` 20 samples later, then `pkt_done`.
  - Required: state sequence 1→2→3→4→5→1.
  - `gain_word`=8'h5A with one `gain_load` pulse; LOCK reached 9 clocks after the decision.
  - `gain_word`=8'h80 after `pkt_done`.
- Detect reset: 3 samples above the threshold, then 1 sample at -70*256, then 3 above. Required: state stays ARM.
- Acquire timeout: no `control_word_valid` for 64 samples. Required: `acq_timeout` pulses once, `agc_clr` pulses, state=ARM, `gain_word`=8'h80.
- Sync miss: reach LOCK with `gain_word`=8'h30, then 256 samples without `sync_found`.
  - Without the macro: `gain_word`=8'h80.
  - With `AGC_CTRL_KEEP_GAIN_EN`: `gain_word` stays 8'h30 and no `gain_load` pulses.
- Simultaneous events: `sync_found` on the expiry sample goes to HOLD; `control_word_valid` on the timeout sample goes to SETTLE with no `acq_timeout`.
- Abort and reset: drop `rx_en` in SETTLE and check IDLE next cycle with `gain_word`=8'h80. Separately, assert `rst_n` low in HOLD and check all outputs at reset values immediately.
